// File: rtl/line_fill_pkg.sv
// Shared types and constants for the line-fill arbiter: FSM states, default
// geometry and the request-index bounds helper.
package line_fill_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 3;
  localparam int DEF_WIDTH = 8;

  // Requesters address entries with a fixed 2-bit index.
  localparam int SEL_W    = 2;
  localparam int SEL_SPAN = 1 << SEL_W;

  function automatic logic sel_in_bounds(input logic [SEL_W-1:0] sel, input int depth);
    return int'(sel) < depth;
  endfunction

endpackage

// File: rtl/line_fill_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, combinational in the request
// cycle; the last-grant pointer only moves when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;  // 1 = requester 1 won most recently

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = last ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/line_fill_arbiter.sv
// Line buffer filled with an incrementing sequence from a seed, then read by
// two round-robin-arbitrated requesters with a one-cycle response.
module line_fill_arbiter
  import line_fill_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill_start,
  input  logic [WIDTH-1:0] base,
  output logic             fill_busy,
  output logic             lines_valid,
  input  logic             req0_valid,
  input  logic [SEL_W-1:0] req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [1:0]       gnt;
  logic             arb_en;
  logic [WIDTH-1:0] rd0, rd1;
  logic             ok0, ok1;

  // Control FSM; fill_busy/lines_valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      base_q      <= '0;
      fill_busy   <= 1'b0;
      lines_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (fill_start) begin
            state       <= S_FILL;
            idx         <= '0;
            base_q      <= base;
            fill_busy   <= 1'b1;
            lines_valid <= 1'b0;
          end
        end
        S_FILL: begin
          if (idx == IDX_LAST) begin
            state       <= S_READY;
            fill_busy   <= 1'b0;
            lines_valid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          fill_busy   <= 1'b0;
          lines_valid <= 1'b0;
        end
      endcase
    end
  end

  // Fill stage: each entry is the previous entry plus one, wrapping at WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_FILL) begin
      if (idx == '0) mem[0] <= base_q;
      for (int i = 1; i < DEPTH; i++)
        if (idx == IDX_W'(i)) mem[i] <= mem[i-1] + WIDTH'(1);
    end
  end

  // A fill request in READY takes priority over reads in that same cycle.
  assign arb_en = (state == S_READY) && !fill_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign ok0 = sel_in_bounds(req0_sel, DEPTH);
  assign ok1 = sel_in_bounds(req1_sel, DEPTH);

  // Out-of-range indices match no entry and so read as zero.
  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(req0_sel) == i) rd0 = mem[i];
      if (int'(req1_sel) == i) rd1 = mem[i];
    end
  end

  // Response stage: data/err only update on a handshake, valid is a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= gnt[0];
      rsp1_valid <= gnt[1];
      if (gnt[0]) begin
        rsp0_data <= ok0 ? rd0 : '0;
        rsp0_err  <= !ok0;
      end
      if (gnt[1]) begin
        rsp1_data <= ok1 ? rd1 : '0;
        rsp1_err  <= !ok1;
      end
    end
  end

endmodule
